// File: rtl/axi_frame_burst_writer.sv
// rtl/axi_frame_burst_writer.sv - AXI3 burst master writing one generated test-pattern frame per pass
`timescale 1ns/1ps
module axi_frame_burst_writer #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                BURST_LEN = 16,
  parameter int                FRAME_W   = 1920,
  parameter int                FRAME_H   = 1080,
  parameter logic [ADDR_W-1:0] FB_BASE   = ADDR_W'(32'h10000000)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [1:0]            pattern_mode,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [3:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  vsync,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  err_sticky
);

  localparam int          PPB         = DATA_W / 32;
  localparam int          BYTES       = DATA_W / 8;
  localparam logic [31:0] TOTAL_BEATS = 32'(FRAME_W * FRAME_H / PPB);
  localparam logic [31:0] BLEN        = 32'(BURST_LEN);
  localparam logic [31:0] PPB32       = 32'(PPB);
  localparam logic [31:0] FRAME_W32   = 32'(FRAME_W);
  localparam logic [31:0] BYTES32     = 32'(BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [3:0]          awlen_q;
  logic                awvalid_q, wvalid_q, wlast_q, bready_q, vsync_q, err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [15:0]         frame_count_q;
  logic [31:0]         beats_left_q, x_q, y_q;
  logic [3:0]          beat_rem_q;
  logic [2:0]          color_q;
  logic [1:0]          mode_q;

  logic [31:0]         x_d, y_d;
  logic [3:0]          first_awlen_d, awlen_d;
  logic [ADDR_W-1:0]   addr_step_d;

  assign m_axi_awsize  = 3'($clog2(BYTES));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_wstrb   = '1;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign vsync         = vsync_q;
  assign busy          = (state_q != IDLE);
  assign frame_count   = frame_count_q;
  assign err_sticky    = err_q;

  // One 0RGB pixel for the latched mode; only x[7:0] and y[3] ever matter
  function automatic logic [31:0] pixel(input logic [1:0] mode, input logic [2:0] cidx,
                                        input logic [7:0] px, input logic py3);
    logic [31:0] p;
    case (mode)
      2'd1: p = {8'h00, px, px, px};
      2'd2: p = (px[3] ^ py3) ? 32'h00FFFFFF : 32'h00000000;
      default: begin
        case (cidx)
          3'd0:    p = 32'h00FF0000;
          3'd1:    p = 32'h0000FF00;
          3'd2:    p = 32'h000000FF;
          3'd3:    p = 32'h00FFFF00;
          3'd4:    p = 32'h00FF00FF;
          3'd5:    p = 32'h0000FFFF;
          default: p = 32'h00FFFFFF;
        endcase
      end
    endcase
    return p;
  endfunction

  // A full beat of PPB pixels starting at x, pixel 0 in the LSBs
  function automatic logic [DATA_W-1:0] beat_data(input logic [1:0] mode, input logic [2:0] cidx,
                                                  input logic [7:0] bx, input logic by3);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < PPB; i++) d[i*32 +: 32] = pixel(mode, cidx, bx + 8'(i), by3);
    return d;
  endfunction

  // Next pixel position, next burst length and address increment
  always_comb begin
    x_d           = x_q + PPB32;
    y_d           = y_q;
    if (x_q + PPB32 == FRAME_W32) begin
      x_d = 32'd0;
      y_d = y_q + 32'd1;
    end
    first_awlen_d = (TOTAL_BEATS >= BLEN) ? 4'(BLEN - 32'd1) : 4'(TOTAL_BEATS - 32'd1);
    awlen_d       = (beats_left_q >= BLEN) ? 4'(BLEN - 32'd1) : 4'(beats_left_q - 32'd1);
    addr_step_d   = ADDR_W'(({28'd0, awlen_q} + 32'd1) * BYTES32);
  end

  // Burst FSM with registered AXI outputs; one transaction outstanding at a time
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      wdata_q       <= '0;
      bready_q      <= 1'b0;
      vsync_q       <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
      beats_left_q  <= '0;
      x_q           <= '0;
      y_q           <= '0;
      beat_rem_q    <= '0;
      color_q       <= '0;
      mode_q        <= '0;
    end else begin
      vsync_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            awaddr_q     <= FB_BASE;
            awlen_q      <= first_awlen_d;
            awvalid_q    <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            beats_left_q <= TOTAL_BEATS;
            mode_q       <= pattern_mode;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b1;
            wlast_q    <= (awlen_q == 4'd0);
            beat_rem_q <= awlen_q;
            wdata_q    <= beat_data(mode_q, color_q, x_q[7:0], y_q[3]);
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (m_axi_wready) begin
            x_q          <= x_d;
            y_q          <= y_d;
            beats_left_q <= beats_left_q - 32'd1;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              beat_rem_q <= beat_rem_q - 4'd1;
              wlast_q    <= (beat_rem_q == 4'd1);
              wdata_q    <= beat_data(mode_q, color_q, x_d[7:0], y_d[3]);
            end
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (m_axi_bresp != 2'b00) err_q <= 1'b1;
            if (beats_left_q != 32'd0) begin
              awaddr_q  <= awaddr_q + addr_step_d;
              awlen_q   <= awlen_d;
              awvalid_q <= 1'b1;
              state_q   <= ADDR;
            end else begin
              vsync_q       <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              color_q       <= (color_q == 3'd6) ? 3'd0 : color_q + 3'd1;
              if (enable) begin
                awaddr_q     <= FB_BASE;
                awlen_q      <= first_awlen_d;
                awvalid_q    <= 1'b1;
                x_q          <= '0;
                y_q          <= '0;
                beats_left_q <= TOTAL_BEATS;
                mode_q       <= pattern_mode;
                state_q      <= ADDR;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_frame_burst_writer.sv
// tb/tb_axi_frame_burst_writer.sv - directed self-checking bench for axi_frame_burst_writer
`timescale 1ns/1ps
module tb_axi_frame_burst_writer;

  localparam int          ADDR_W    = 32;
  localparam int          DATA_W    = 64;
  localparam int          BURST_LEN = 4;
  localparam int          FRAME_W   = 18;
  localparam int          FRAME_H   = 9;
  localparam int          BEATS     = 81;   // 18*9/2
  localparam int          BPL       = 9;    // beats per line
  localparam int          NBURST    = 21;   // 20 full bursts + one 1-beat burst
  localparam logic [31:0] BASE      = 32'h10000000;
  localparam logic [31:0] COLOURS [7] = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00FFFF00,
                                          32'h00FF00FF, 32'h0000FFFF, 32'h00FFFFFF};

  logic                aclk, areset, enable;
  logic [1:0]          pattern_mode;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [3:0]          m_axi_awlen, m_axi_awcache;
  logic [2:0]          m_axi_awsize, m_axi_awprot;
  logic [1:0]          m_axi_awburst, m_axi_bresp;
  logic                m_axi_awvalid, m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic                m_axi_bvalid, m_axi_bready;
  logic                vsync, busy, err_sticky;
  logic [15:0]         frame_count;

  axi_frame_burst_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .FB_BASE(BASE)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .pattern_mode(pattern_mode),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .vsync(vsync), .busy(busy), .frame_count(frame_count), .err_sticky(err_sticky)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction logs filled by the monitor
  logic [31:0] aw_addr_log[$];
  logic [3:0]  aw_len_log[$];
  logic [63:0] w_data_log[$];
  logic        w_last_log[$];
  logic [63:0] data_a[$], data_b[$];
  int          b_cnt, vs_cnt, overlap_cnt;
  bit          stall_en, inject_en;

  task automatic clear_logs();
    aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete(); w_last_log.delete();
    b_cnt = 0; vs_cnt = 0;
  endtask

  // Monitor: sample on the falling edge, predict handshakes of the next rising edge
  initial begin
    bit          aw_stall, w_stall;
    logic [31:0] p_awaddr;
    logic [3:0]  p_awlen;
    logic [63:0] p_wdata;
    logic        p_wlast;
    aw_stall = 0; w_stall = 0; overlap_cnt = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        aw_stall = 0; w_stall = 0;
      end else begin
        if (aw_stall) check("aw_hold", {m_axi_awvalid, m_axi_awlen, m_axi_awaddr}, {1'b1, p_awlen, p_awaddr});
        if (w_stall) begin
          check("w_hold_data", m_axi_wdata, p_wdata);
          check("w_hold_ctl", {m_axi_wvalid, m_axi_wlast}, {1'b1, p_wlast});
        end
        aw_stall = m_axi_awvalid && !m_axi_awready;
        w_stall  = m_axi_wvalid && !m_axi_wready;
        p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
        p_wdata  = m_axi_wdata;  p_wlast = m_axi_wlast;
        if (m_axi_awvalid && m_axi_awready) begin aw_addr_log.push_back(m_axi_awaddr); aw_len_log.push_back(m_axi_awlen); end
        if (m_axi_wvalid && m_axi_wready) begin w_data_log.push_back(m_axi_wdata); w_last_log.push_back(m_axi_wlast); end
        if (m_axi_bvalid && m_axi_bready) b_cnt++;
        if (vsync) vs_cnt++;
        if (m_axi_awvalid && m_axi_wvalid) overlap_cnt++;
      end
    end
  end

  // Slave responder: inputs change 1 ns after the rising edge
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    forever begin
      @(posedge aclk); #1;
      if (stall_en) begin
        m_axi_awready = ($urandom_range(0, 2) != 0);
        m_axi_wready  = ($urandom_range(0, 2) != 0);
        m_axi_bvalid  = m_axi_bready && ($urandom_range(0, 2) != 0);
      end else begin
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = m_axi_bready;
      end
      m_axi_bresp = (inject_en && b_cnt == 1) ? 2'b10 : 2'b00;
    end
  end

  function automatic logic [31:0] ref_px(input int mode, input int colour, input int x, input int y);
    logic [7:0] v;
    v = 8'(x);
    if (mode == 1) return {8'h00, v, v, v};
    if (mode == 2) return ((((x / 8) + (y / 8)) % 2) == 1) ? 32'h00FFFFFF : 32'h00000000;
    return COLOURS[colour];
  endfunction

  task automatic verify_frame(input string name, input int aw0, input int w0, input int mode, input int colour);
    int          bad_aw, bad_last, bad_data, x, y;
    logic [31:0] ea;
    logic [3:0]  el;
    logic [63:0] ed;
    logic        elast;
    bad_aw = 0; bad_last = 0; bad_data = 0;
    for (int i = 0; i < NBURST; i++) begin
      ea = BASE + 32'(32 * i);
      el = (i == NBURST - 1) ? 4'd0 : 4'd3;
      if (aw0 + i >= aw_addr_log.size()) bad_aw++;
      else if (aw_addr_log[aw0 + i] !== ea || aw_len_log[aw0 + i] !== el) bad_aw++;
    end
    for (int b = 0; b < BEATS; b++) begin
      x = (b % BPL) * 2; y = b / BPL;
      ed = {ref_px(mode, colour, x + 1, y), ref_px(mode, colour, x, y)};
      elast = ((b % 4) == 3) || (b == BEATS - 1);
      if (w0 + b >= w_data_log.size()) begin bad_data++; bad_last++; end
      else begin
        if (w_data_log[w0 + b] !== ed) bad_data++;
        if (w_last_log[w0 + b] !== elast) bad_last++;
      end
    end
    check({name, "_aw_addr_len"}, bad_aw, 0);
    check({name, "_wlast_pos"}, bad_last, 0);
    check({name, "_wdata"}, bad_data, 0);
  endtask

  task automatic wait_vsync(input string name, input int budget);
    int n;
    n = 0;
    while (vsync !== 1'b1 && n < budget) begin @(negedge aclk); n++; end
    check({name, "_vsync_timeout"}, (n < budget), 1'b1);
  endtask

  typedef struct {
    string       name;
    int          frame;
    int          beat;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n;
    logic [63:0] act;

    vecs[0]  = '{"ramp_b0",       0, 0,  64'h00010101_00000000};
    vecs[1]  = '{"ramp_b4",       0, 4,  64'h00090909_00080808};
    vecs[2]  = '{"ramp_b8",       0, 8,  64'h00111111_00101010};
    vecs[3]  = '{"ramp_b9_y1",    0, 9,  64'h00010101_00000000};
    vecs[4]  = '{"ramp_b80",      0, 80, 64'h00111111_00101010};
    vecs[5]  = '{"chk_b0",        1, 0,  64'h00000000_00000000};
    vecs[6]  = '{"chk_b4_x8",     1, 4,  64'h00FFFFFF_00FFFFFF};
    vecs[7]  = '{"chk_b13_y1x8",  1, 13, 64'h00FFFFFF_00FFFFFF};
    vecs[8]  = '{"chk_b72_y8x0",  1, 72, 64'h00FFFFFF_00FFFFFF};
    vecs[9]  = '{"chk_b76_y8x8",  1, 76, 64'h00000000_00000000};
    vecs[10] = '{"chk_b80_y8x16", 1, 80, 64'h00FFFFFF_00FFFFFF};

    areset = 1'b1; enable = 1'b0; pattern_mode = 2'd0; stall_en = 0; inject_en = 0;
    clear_logs();
    repeat (3) @(negedge aclk);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_awlen", m_axi_awlen, 0);
    check("rst_wvalid_wlast_bready", {m_axi_wvalid, m_axi_wlast, m_axi_bready}, 0);
    check("rst_wdata", m_axi_wdata, 0);
    check("rst_status", {vsync, busy, err_sticky, frame_count}, 0);
    check("const_awsize", m_axi_awsize, 3);
    check("const_awburst", m_axi_awburst, 1);
    check("const_cache_prot", {m_axi_awcache, m_axi_awprot}, 0);
    check("const_wstrb", m_axi_wstrb, 8'hFF);
    areset = 1'b0;
    @(negedge aclk);

    // Frame A: ramp, no stalls, enable dropped mid-frame
    pattern_mode = 2'd1; enable = 1'b1;
    @(negedge aclk);
    check("A_busy", busy, 1);
    check("A_aw_latency", m_axi_awvalid, 1);
    check("A_first_aw", {m_axi_awlen, m_axi_awaddr}, {4'd3, BASE});
    @(negedge aclk);
    check("A_w_latency", {m_axi_wvalid, m_axi_awvalid}, 2'b10);
    repeat (20) @(negedge aclk);
    enable = 1'b0;
    wait_vsync("A", 1000);
    check("A_frame_count", frame_count, 1);
    check("A_busy_after", busy, 0);
    @(negedge aclk);
    check("A_vsync_one_cycle", vsync, 0);
    check("A_counts", {16'(aw_addr_log.size()), 16'(w_data_log.size()), 16'(b_cnt), 16'(vs_cnt)},
          {16'd21, 16'd81, 16'd21, 16'd1});
    check("A_err", err_sticky, 0);
    verify_frame("A", 0, 0, 1, 0);
    data_a = w_data_log;

    // Frame B: checker, random stalls, error response on burst 2
    clear_logs();
    pattern_mode = 2'd2; stall_en = 1; inject_en = 1; enable = 1'b1;
    repeat (30) @(negedge aclk);
    enable = 1'b0;
    wait_vsync("B", 4000);
    check("B_frame_count", frame_count, 2);
    check("B_err_sticky", err_sticky, 1);
    @(negedge aclk);
    stall_en = 0; inject_en = 0;
    repeat (3) @(negedge aclk);
    check("B_counts", {16'(aw_addr_log.size()), 16'(w_data_log.size()), 16'(b_cnt), 16'(vs_cnt)},
          {16'd21, 16'd81, 16'd21, 16'd1});
    verify_frame("B", 0, 0, 2, 0);
    data_b = w_data_log;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].frame == 0) act = (vecs[i].beat < data_a.size()) ? data_a[vecs[i].beat] : 64'hDEAD;
      else                    act = (vecs[i].beat < data_b.size()) ? data_b[vecs[i].beat] : 64'hDEAD;
      check(vecs[i].name, act, vecs[i].exp);
    end

    // Frames C and D back-to-back: solid colour, mode changed mid-frame C to 3
    clear_logs();
    pattern_mode = 2'd0; enable = 1'b1;
    repeat (20) @(negedge aclk);
    pattern_mode = 2'd3;
    wait_vsync("C", 1000);
    check("C_frame_count", frame_count, 3);
    check("C_restart_busy", busy, 1);
    @(negedge aclk);
    repeat (20) @(negedge aclk);
    enable = 1'b0;
    wait_vsync("D", 1000);
    check("D_frame_count", frame_count, 4);
    check("D_busy_after", busy, 0);
    @(negedge aclk);
    check("CD_counts", {16'(aw_addr_log.size()), 16'(w_data_log.size()), 16'(vs_cnt)},
          {16'd42, 16'd162, 16'd2});
    verify_frame("C_blue", 0, 0, 0, 2);
    verify_frame("D_yellow", 21, 81, 0, 3);
    check("CD_err_held", err_sticky, 1);

    // Reset in the middle of a data burst
    pattern_mode = 2'd1; enable = 1'b1;
    n = 0;
    while (m_axi_wvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    check("R_wait_wvalid", (n < 50), 1'b1);
    #2 areset = 1'b1;
    #1;
    check("R_async_clear", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, busy}, 0);
    @(posedge aclk); #1;
    check("R_outputs", {m_axi_awaddr, m_axi_awlen, m_axi_wvalid, m_axi_wlast}, 0);
    check("R_status", {frame_count, err_sticky, vsync}, 0);
    check("R_wdata", m_axi_wdata, 0);
    @(negedge aclk);
    clear_logs();
    areset = 1'b0;
    @(negedge aclk);
    check("R_restart_aw", {m_axi_awvalid, m_axi_awaddr}, {1'b1, BASE});
    check("R_restart_count", frame_count, 0);
    repeat (10) @(negedge aclk);
    enable = 1'b0;
    wait_vsync("R", 1000);
    check("R_frame_count", frame_count, 1);
    @(negedge aclk);
    check("R_beats", w_data_log.size(), 81);
    verify_frame("R", 0, 0, 1, 0);
    check("no_aw_w_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
